// File: rtl/arith_sched_pkg.sv
// arith_sched_pkg: op codes, scheduler states and the round-robin pick shared by the scheduler.
package arith_sched_pkg;
   typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11} op_t;
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   // First set bit of mask searching upward from last+1, wrapping at nreq; returns last if none.
   function automatic logic [3:0] rr_next(input logic [15:0] mask, input logic [3:0] last, input int nreq);
      logic [3:0] g;
      logic [3:0] idx;
      logic f;
      g = last;
      f = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         idx = 4'((int'(last) + k) % nreq);
         if (!f && k <= nreq && mask[idx]) begin
            g = idx;
            f = 1'b1;
         end
      end
      return g;
   endfunction
endpackage

// File: rtl/arith_div_iter.sv
// arith_div_iter: restoring shift-subtract divider, one quotient bit per cycle starting on the start edge.
module arith_div_iter #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         done,
   output logic [N-1:0] q,
   output logic [N-1:0] r
);
   localparam int CW = $clog2(N + 1);
   logic [CW-1:0] cnt;
   logic [N-1:0] dvs, rem_in, quo_in, dv;
   logic [N:0] sh, diff;
   logic ge;
   // The start edge already performs the first step on the incoming operands.
   always_comb begin
      rem_in = start ? '0 : r;
      quo_in = start ? a : q;
      dv = start ? b : dvs;
      sh = {rem_in, quo_in[N-1]};
      diff = sh - {1'b0, dv};
      ge = !diff[N];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         dvs <= '0;
         q <= '0;
         r <= '0;
         done <= 1'b0;
      end else begin
         done <= start ? (N == 1) : (cnt == CW'(1));
         if (start || cnt != '0) begin
            r <= ge ? diff[N-1:0] : sh[N-1:0];
            q <= {quo_in[N-2:0], ge};
            cnt <= start ? CW'(N - 1) : cnt - CW'(1);
         end
         if (start) dvs <= b;
      end
   end
endmodule

// File: rtl/arith_unit_scheduler.sv
// arith_unit_scheduler: round-robin shared add/sub/mul/div engine with one op in flight.
// ARITH_SCHED_PRIO0_EN gives requester 0 strict priority over the round-robin group.
module arith_unit_scheduler
   import arith_sched_pkg::*;
#(
   parameter int N = 8,
   parameter int NREQ = 4,
   parameter int MUL_LAT = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [2*NREQ-1:0]        req_op,
   input  logic [N*NREQ-1:0]        req_a,
   input  logic [N*NREQ-1:0]        req_b,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic [2*N-1:0]           rsp_data,
   output logic                     rsp_err
);
   localparam int IDW = $clog2(NREQ);
   localparam int W2 = 2 * N;
   localparam int CW = $clog2((N > MUL_LAT ? N : MUL_LAT) + 1);
   state_t state, state_n;
   op_t op, sel_op;
   logic [N-1:0] a, b, sel_a, sel_b, div_q, div_r;
   logic [IDW-1:0] last, g;
   logic [CW-1:0] cnt, lat;
   logic acc, upd, fin, div0, div_done;
   logic [W2-1:0] res;
   logic [W2-1:0] mpipe [MUL_LAT];
   always_comb begin
`ifdef ARITH_SCHED_PRIO0_EN
      g = req_valid[0] ? '0 : IDW'(rr_next(16'(req_valid & ~NREQ'(1)), 4'(last), NREQ));
      upd = !req_valid[0];
`else
      g = IDW'(rr_next(16'(req_valid), 4'(last), NREQ));
      upd = 1'b1;
`endif
      acc = state == IDLE && |req_valid;
      req_ready = acc ? NREQ'(1) << g : '0;
      sel_op = op_t'(req_op[2*g +: 2]);
      sel_a = req_a[N*g +: N];
      sel_b = req_b[N*g +: N];
      lat = sel_op == OP_MUL ? CW'(MUL_LAT) : (sel_op == OP_DIV && sel_b != '0) ? CW'(N) : CW'(1);
      div0 = op == OP_DIV && b == '0;
      fin = (op == OP_DIV && !div0) ? div_done : cnt == CW'(1);
      res = op == OP_ADD ? {{(N-1){1'b0}}, {1'b0, a} + {1'b0, b}} :
            op == OP_SUB ? {{N{1'b0}}, a - b} :
            op == OP_MUL ? mpipe[MUL_LAT-1] :
            div0 ? {a, {N{1'b1}}} : {div_r, div_q};
      state_n = state == IDLE ? (acc ? EXEC : IDLE) :
                state == EXEC ? (fin ? RESP : EXEC) :
                (rsp_ready ? IDLE : RESP);
   end
   assign rsp_valid = state == RESP;
   arith_div_iter #(.N(N)) u_div (
      .clk(clk), .rst_n(rst_n), .start(acc && sel_op == OP_DIV),
      .a(sel_a), .b(sel_b), .done(div_done), .q(div_q), .r(div_r)
   );
   // Stage 0 captures the product on the accepting edge, so the tap is valid MUL_LAT-1 edges later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MUL_LAT; i++) mpipe[i] <= '0;
      end else begin
         mpipe[0] <= W2'(sel_a) * W2'(sel_b);
         for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         last <= IDW'(NREQ - 1);
         cnt <= '0;
         op <= OP_ADD;
         a <= '0;
         b <= '0;
         rsp_id <= '0;
         rsp_data <= '0;
         rsp_err <= 1'b0;
      end else begin
         state <= state_n;
         if (acc) begin
            op <= sel_op;
            a <= sel_a;
            b <= sel_b;
            rsp_id <= g;
            cnt <= lat;
            if (upd) last <= g;
         end else if (state == EXEC) cnt <= cnt - CW'(1);
         if (state == EXEC && fin) begin
            rsp_data <= res;
            rsp_err <= div0;
         end
      end
   end
endmodule

// File: tb/tb_arith_unit_scheduler.sv
// tb_arith_unit_scheduler: randomized and directed checks of the shared arithmetic scheduler.
module tb_arith_unit_scheduler;
   localparam int N = 8, NREQ = 4, MUL_LAT = 2;
   logic clk = 0, rst_n = 0, rsp_ready = 1;
   logic [NREQ-1:0] req_valid = '0, req_ready;
   logic [2*NREQ-1:0] req_op = '0;
   logic [N*NREQ-1:0] req_a = '0, req_b = '0;
   logic rsp_valid, rsp_err;
   logic [1:0] rsp_id;
   logic [2*N-1:0] rsp_data;
   int total = 0, bad = 0, cyc = 0;

   arith_unit_scheduler #(.N(N), .NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Reference result {err, data} from plain unsigned arithmetic.
   function automatic logic [16:0] model(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
      case (op)
         2'd0: return {1'b0, 16'(x) + 16'(y)};
         2'd1: return {1'b0, 8'h00, 8'(x - y)};
         2'd2: return {1'b0, 16'(x) * 16'(y)};
         default: return y == 0 ? {1'b1, x, 8'hFF} : {1'b0, 8'(x % y), 8'(x / y)};
      endcase
   endfunction

   function automatic int model_lat(input logic [1:0] op, input logic [7:0] y);
      return op == 2'd2 ? MUL_LAT : (op == 2'd3 && y != 0) ? N : 1;
   endfunction

   task automatic do_op(input int id, input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                        output int lat, output logic [15:0] data, output logic [1:0] rid,
                        output logic err, output bit ok);
      int e;
      ok = 0; lat = -1; data = '0; rid = '0; err = 0;
      @(negedge clk);
      req_valid = '0;
      req_op[2*id +: 2] = op;
      req_a[8*id +: 8] = x;
      req_b[8*id +: 8] = y;
      req_valid[id] = 1'b1;
      for (int t = 0; t < 40; t++) begin
         #1;
         if (req_ready[id]) begin ok = 1; break; end
         @(negedge clk);
      end
      e = cyc + 1;
      if (ok) @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      if (!ok) return;
      ok = 0;
      for (int t = 0; t < 40; t++) begin
         if (rsp_valid) begin ok = 1; lat = cyc - e; break; end
         @(negedge clk);
      end
      data = rsp_data; rid = rsp_id; err = rsp_err;
      if (ok) @(posedge clk);
   endtask

   task automatic test_reset();
      int hits = 0;
      repeat (3) @(negedge clk);
      #1;
      total++;
      if ({rsp_valid, req_ready, rsp_data, rsp_id, rsp_err} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got v=%b rdy=%b d=%0d id=%0d e=%b want all zero", rsp_valid, req_ready, rsp_data, rsp_id, rsp_err);
      end
      @(negedge clk);
      rst_n = 1;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk); #1;
         if (rsp_valid || req_ready != 0) hits++;
      end
      total++;
      if (hits !== 0) begin bad++; $display("FAIL idle_quiet got %0d active cycles want 0", hits); end
   endtask

   task automatic test_directed();
      int ids[5] = '{2, 1, 0, 3, 3};
      logic [1:0] ops[5] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd3};
      logic [7:0] xs[5] = '{200, 255, 5, 100, 9};
      logic [7:0] ys[5] = '{100, 255, 7, 7, 0};
      int lat; logic [15:0] d; logic [1:0] rid; logic err; bit ok; logic [16:0] m;
      for (int k = 0; k < 5; k++) begin
         do_op(ids[k], ops[k], xs[k], ys[k], lat, d, rid, err, ok);
         m = model(ops[k], xs[k], ys[k]);
         total++;
         if (!ok || lat !== model_lat(ops[k], ys[k])) begin bad++; $display("FAIL dir%0d_latency got %0d want %0d", k, lat, model_lat(ops[k], ys[k])); end
         total++;
         if (d !== m[15:0]) begin bad++; $display("FAIL dir%0d_data got %0d want %0d", k, d, m[15:0]); end
         total++;
         if (rid !== 2'(ids[k])) begin bad++; $display("FAIL dir%0d_id got %0d want %0d", k, rid, ids[k]); end
         total++;
         if (err !== m[16]) begin bad++; $display("FAIL dir%0d_err got %b want %b", k, err, m[16]); end
         @(negedge clk); #1;
         total++;
         if (rsp_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_valid_drop got %b want 0", k, rsp_valid); end
      end
   endtask

   task automatic test_random();
      int lat, id; logic [15:0] d; logic [1:0] rid, op; logic err; bit ok; logic [7:0] x, y; logic [16:0] m;
      for (int k = 0; k < 40; k++) begin
         id = $urandom_range(0, NREQ - 1);
         op = 2'($urandom_range(0, 3));
         x = 8'($urandom);
         y = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         do_op(id, op, x, y, lat, d, rid, err, ok);
         m = model(op, x, y);
         total++;
         if (!ok || lat !== model_lat(op, y) || d !== m[15:0] || err !== m[16] || rid !== 2'(id))
            begin
               bad++;
               $display("FAIL rand%0d op=%0d a=%0d b=%0d got lat=%0d d=%0d e=%b id=%0d want lat=%0d d=%0d e=%b id=%0d",
                        k, op, x, y, lat, d, err, rid, model_lat(op, y), m[15:0], m[16], id);
            end
      end
   endtask

   task automatic test_back_to_back();
      int got[6] = '{-1, -1, -1, -1, -1, -1};
      int n = 0, w;
      @(negedge clk); rst_n = 0;
      @(negedge clk); rst_n = 1;
      req_op = '0;
      for (int i = 0; i < NREQ; i++) begin req_a[8*i +: 8] = 8'(i); req_b[8*i +: 8] = 8'd1; end
      req_valid = '1;
      for (int t = 0; t < 100 && n < 6; t++) begin
         #1;
         if (req_ready != 0) begin
            for (int j = 0; j < NREQ; j++) if (req_ready[j]) got[n] = j;
            n++;
         end
         @(negedge clk);
      end
      req_valid = '0;
      repeat (10) @(negedge clk);
      for (int k = 0; k < 6; k++) begin
`ifdef ARITH_SCHED_PRIO0_EN
         w = 0;
`else
         w = k % NREQ;
`endif
         total++;
         if (got[k] !== w) begin bad++; $display("FAIL grant%0d got %0d want %0d", k, got[k], w); end
      end
   endtask

   task automatic test_stall();
      int lat, hits = 0; logic [15:0] d; logic [1:0] rid; logic err; bit ok;
      rsp_ready = 0;
      do_op(1, 2'd2, 8'd12, 8'd13, lat, d, rid, err, ok);
      total++;
      if (!ok || d !== 16'd156) begin bad++; $display("FAIL stall_result got ok=%0d d=%0d want d=156", ok, d); end
      @(negedge clk);
      req_op[7:6] = 2'd0; req_a[31:24] = 8'd3; req_b[31:24] = 8'd4;
      req_valid = 4'b1000;
      for (int t = 0; t < 5; t++) begin
         #1;
         if (rsp_valid !== 1 || rsp_data !== 16'd156 || rsp_id !== 2'd1 || rsp_err !== 0 || req_ready !== '0) hits++;
         @(negedge clk);
      end
      total++;
      if (hits !== 0) begin bad++; $display("FAIL stall_hold got %0d unstable cycles want 0", hits); end
      rsp_ready = 1;
      @(posedge clk); @(negedge clk); #1;
      total++;
      if (rsp_valid !== 0 || req_ready !== 4'b1000) begin
         bad++; $display("FAIL stall_release got v=%b rdy=%b want v=0 rdy=1000", rsp_valid, req_ready);
      end
      @(posedge clk); @(negedge clk);
      req_valid = '0;
      ok = 0;
      for (int t = 0; t < 20 && !ok; t++) begin
         if (rsp_valid) ok = 1; else @(negedge clk);
      end
      total++;
      if (!ok || rsp_data !== 16'd7 || rsp_id !== 2'd3) begin
         bad++; $display("FAIL stall_waiter got ok=%0d d=%0d id=%0d want d=7 id=3", ok, rsp_data, rsp_id);
      end
      @(negedge clk);
   endtask

   task automatic test_abort();
      int hits = 0; bit ok = 0;
      @(negedge clk);
      req_op[5:4] = 2'd3; req_a[23:16] = 8'd200; req_b[23:16] = 8'd3;
      req_valid = 4'b0100;
      for (int t = 0; t < 20 && !ok; t++) begin
         #1;
         if (req_ready[2]) ok = 1; else @(negedge clk);
      end
      @(posedge clk); @(negedge clk);
      req_valid = '0;
      repeat (3) @(negedge clk);
      #2 rst_n = 0;
      #1;
      total++;
      if (!ok || rsp_valid !== 0 || rsp_data !== '0 || rsp_id !== '0 || rsp_err !== 0) begin
         bad++; $display("FAIL abort_clear got ok=%0d v=%b d=%0d id=%0d e=%b want zeros", ok, rsp_valid, rsp_data, rsp_id, rsp_err);
      end
      @(negedge clk); rst_n = 1;
      for (int t = 0; t < 12; t++) begin
         @(negedge clk);
         if (rsp_valid) hits++;
      end
      total++;
      if (hits !== 0) begin bad++; $display("FAIL abort_no_resp got %0d valid cycles want 0", hits); end
      req_op = '0;
      for (int i = 0; i < NREQ; i++) begin req_a[8*i +: 8] = 8'd50; req_b[8*i +: 8] = 8'(60 + i); end
      req_valid = '1;
      #1;
      total++;
      if (req_ready !== 4'b0001) begin bad++; $display("FAIL abort_regrant got %b want 0001", req_ready); end
      @(posedge clk); @(negedge clk);
      req_valid = '0;
      ok = 0;
      for (int t = 0; t < 20 && !ok; t++) begin
         if (rsp_valid) ok = 1; else @(negedge clk);
      end
      total++;
      if (!ok || rsp_data !== 16'd110 || rsp_id !== 2'd0) begin
         bad++; $display("FAIL abort_resume got ok=%0d d=%0d id=%0d want d=110 id=0", ok, rsp_data, rsp_id);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_stall();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
